// File: rtl/vvm_result_serializer.sv
// Snapshots one phase_processor result set and streams it as a 9-word frame
// (header + mag/phase per channel) on a registered valid/ready interface.
module vvm_result_serializer #(
    parameter int MAG_W   = 21,
    parameter int PHASE_W = 22
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst_n,
    input  logic        [MAG_W-1:0]   mags,
    input  logic        [MAG_W-1:0]   mags_1,
    input  logic        [MAG_W-1:0]   mags_2,
    input  logic        [MAG_W-1:0]   mags_3,
    input  logic signed [PHASE_W-1:0] phases,
    input  logic signed [PHASE_W-1:0] phases_1,
    input  logic signed [PHASE_W-1:0] phases_2,
    input  logic signed [PHASE_W-1:0] phases_3,
    input  logic                      strobe_in,
    input  logic                      enable,
    input  logic                      overrun_clr,
    input  logic                      out_ready,
    output logic        [31:0]        out_data,
    output logic                      out_valid,
    output logic                      out_last,
    output logic                      busy,
    output logic        [15:0]        overrun_cnt,
    output logic        [15:0]        frame_cnt
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                    state, state_nxt;
    logic        [MAG_W-1:0]   mag_in [4];
    logic signed [PHASE_W-1:0] ph_in  [4];
    logic        [MAG_W-1:0]   mag_sh [4];
    logic signed [PHASE_W-1:0] ph_sh  [4];
    logic        [3:0]         idx, idx_nxt;
    logic        [31:0]        data_nxt;
    logic                      last_nxt;
    logic        [15:0]        frame_cnt_nxt, overrun_cnt_nxt;
    logic                      accept, hs, final_hs, load, overrun;

    assign mag_in = '{mags, mags_1, mags_2, mags_3};
    assign ph_in  = '{phases, phases_1, phases_2, phases_3};

    function automatic logic [31:0] zext_mag(input logic [MAG_W-1:0] m);
        return 32'(m);
    endfunction

    function automatic logic [31:0] sext_phase(input logic signed [PHASE_W-1:0] p);
        return 32'(p);
    endfunction

    // Payload words 1..8 alternate mag/phase, channel = (i-1)/2.
    function automatic logic [31:0] word_sel(input logic [3:0] i);
        logic [3:0] k;
        k = i - 4'd1;
        if (k[0]) return sext_phase(ph_sh[k[2:1]]);
        else      return zext_mag(mag_sh[k[2:1]]);
    endfunction

    assign accept   = strobe_in && enable;
    assign hs       = out_valid && out_ready;
    assign final_hs = hs && (idx == 4'd8);
    // The final handshake cycle is the only SEND cycle that may take a new set.
    assign load     = accept && ((state == IDLE) || final_hs);
    assign overrun  = accept && (state == SEND) && !final_hs;
    assign busy     = (state == SEND);
    assign out_valid = (state == SEND);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (load) state_nxt = SEND;
            SEND:    if (final_hs && !load) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        frame_cnt_nxt = final_hs ? frame_cnt + 16'd1 : frame_cnt;

        overrun_cnt_nxt = overrun_cnt;
        if (overrun_clr)                        overrun_cnt_nxt = overrun ? 16'd1 : 16'd0;
        else if (overrun && overrun_cnt != 16'hFFFF) overrun_cnt_nxt = overrun_cnt + 16'd1;

        idx_nxt  = idx;
        data_nxt = out_data;
        last_nxt = out_last;
        if (load) begin
            idx_nxt  = 4'd0;
            data_nxt = {8'hA5, frame_cnt_nxt, 8'd8};
            last_nxt = 1'b0;
        end else if (hs && idx != 4'd8) begin
            idx_nxt  = idx + 4'd1;
            data_nxt = word_sel(idx + 4'd1);
            last_nxt = (idx == 4'd7);
        end else if (final_hs) begin
            idx_nxt  = 4'd0;
            data_nxt = 32'd0;
            last_nxt = 1'b0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int c = 0; c < 4; c++) begin
                mag_sh[c] <= '0;
                ph_sh[c]  <= '0;
            end
            idx         <= 4'd0;
            out_data    <= 32'd0;
            out_last    <= 1'b0;
            overrun_cnt <= 16'd0;
            frame_cnt   <= 16'd0;
        end else begin
            if (load) begin
                for (int c = 0; c < 4; c++) begin
                    mag_sh[c] <= mag_in[c];
                    ph_sh[c]  <= ph_in[c];
                end
            end
            idx         <= idx_nxt;
            out_data    <= data_nxt;
            out_last    <= last_nxt;
            overrun_cnt <= overrun_cnt_nxt;
            frame_cnt   <= frame_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_vvm_result_serializer.sv
// Scoreboard bench for vvm_result_serializer: frames are predicted at strobe
// acceptance and popped on each predicted handshake.
module tb_vvm_result_serializer;

    logic               sys_clk = 1'b0;
    logic               sys_rst_n = 1'b0;
    logic        [20:0] mags, mags_1, mags_2, mags_3;
    logic signed [21:0] phases, phases_1, phases_2, phases_3;
    logic               strobe_in = 1'b0, enable = 1'b1, overrun_clr = 1'b0, out_ready = 1'b1;
    logic        [31:0] out_data;
    logic               out_valid, out_last, busy;
    logic        [15:0] overrun_cnt, frame_cnt;

    int n_checks = 0;
    int n_errors = 0;

    logic [32:0] exp_q[$];
    logic        m_busy = 1'b0;
    int          m_idx = 0;
    logic [15:0] m_frame = 16'd0;
    logic        stall_pend = 1'b0;
    logic [31:0] st_data;
    logic        st_last;

    vvm_result_serializer #(.MAG_W(21), .PHASE_W(22)) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .mags(mags), .mags_1(mags_1), .mags_2(mags_2), .mags_3(mags_3),
        .phases(phases), .phases_1(phases_1), .phases_2(phases_2), .phases_3(phases_3),
        .strobe_in(strobe_in), .enable(enable), .overrun_clr(overrun_clr),
        .out_ready(out_ready), .out_data(out_data), .out_valid(out_valid),
        .out_last(out_last), .busy(busy), .overrun_cnt(overrun_cnt), .frame_cnt(frame_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] zx(input logic [20:0] m);
        return {11'd0, m};
    endfunction

    function automatic logic [31:0] sx(input logic [21:0] p);
        return {{10{p[21]}}, p};
    endfunction

    task automatic push_frame(input logic [15:0] fc);
        exp_q.push_back({1'b0, 8'hA5, fc, 8'd8});
        exp_q.push_back({1'b0, zx(mags)});
        exp_q.push_back({1'b0, sx(phases)});
        exp_q.push_back({1'b0, zx(mags_1)});
        exp_q.push_back({1'b0, sx(phases_1)});
        exp_q.push_back({1'b0, zx(mags_2)});
        exp_q.push_back({1'b0, sx(phases_2)});
        exp_q.push_back({1'b0, zx(mags_3)});
        exp_q.push_back({1'b1, sx(phases_3)});
    endtask

    // Inputs change at posedge+1, so at negedge they are what the next edge samples.
    always @(negedge sys_clk) begin
        logic [32:0] e;
        if (!sys_rst_n) begin
            exp_q.delete();
            m_busy = 1'b0; m_idx = 0; m_frame = 16'd0; stall_pend = 1'b0;
        end else begin
            check("valid", {31'd0, out_valid}, {31'd0, m_busy});
            check("busy", {31'd0, busy}, {31'd0, m_busy});
            if (stall_pend) begin
                check("stall_data", out_data, st_data);
                check("stall_last", {31'd0, out_last}, {31'd0, st_last});
            end
            stall_pend = m_busy && !out_ready;
            st_data = out_data; st_last = out_last;
            if (m_busy && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("word", out_data, e[31:0]);
                    check("last", {31'd0, out_last}, {31'd0, e[32]});
                end
                if (m_idx == 8) begin
                    m_busy = 1'b0; m_frame++;
                end else m_idx++;
            end
            if (strobe_in && enable && !m_busy) begin
                push_frame(m_frame);
                m_busy = 1'b1; m_idx = 0;
            end
        end
    end

    task automatic tick();
        @(posedge sys_clk); #1;
    endtask

    task automatic strobe();
        strobe_in = 1'b1; tick(); strobe_in = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300 && out_valid; i++) begin
            if (out_ready === 1'b0 && i > 200) out_ready = 1'b1;
            tick();
        end
        check("idle_timeout", {31'd0, out_valid}, 32'd0);
        check("sb_empty", exp_q.size(), 32'd0);
    endtask

    task automatic set_all(input logic [20:0] m, input logic [21:0] p);
        mags = m; mags_1 = m; mags_2 = m; mags_3 = m;
        phases = p; phases_1 = p; phases_2 = p; phases_3 = p;
    endtask

    initial begin
        set_all(21'd1, 22'd2);
        #1;
        check("rst_data", out_data, 32'd0);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_ovr", {16'd0, overrun_cnt}, 32'd0);
        check("rst_frame", {16'd0, frame_cnt}, 32'd0);
        tick(); tick();
        sys_rst_n = 1'b1;
        tick();

        // Basic frame
        strobe();
        check("basic_hdr", out_data, 32'hA500_0008);
        wait_idle();
        check("basic_fcnt", {16'd0, frame_cnt}, 32'd1);

        // Sign and width extension
        set_all(21'd1, 22'd2);
        phases_3 = 22'h3FFFFF; mags_2 = 21'h1FFFFF;
        strobe();
        set_all(21'd0, 22'd0);
        wait_idle();

        // Backpressure with inputs churning after the snapshot
        set_all(21'h0ABCDE, -22'sd12345);
        strobe();
        for (int i = 0; i < 200 && out_valid; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            set_all(21'($urandom), 22'($urandom));
            tick();
        end
        out_ready = 1'b1;
        wait_idle();

        // Overrun: three dropped strobes during a stalled frame
        out_ready = 1'b0;
        set_all(21'd7, -22'sd7);
        strobe();
        set_all(21'd9, 22'd9);
        for (int i = 0; i < 3; i++) begin strobe(); tick(); end
        check("ovr_3", {16'd0, overrun_cnt}, 32'd3);
        out_ready = 1'b1;
        wait_idle();
        out_ready = 1'b0;
        strobe();
        overrun_clr = 1'b1; strobe(); overrun_clr = 1'b0;
        check("ovr_clr", {16'd0, overrun_cnt}, 32'd1);
        strobe_in = 1'b1;
        for (int i = 0; i < 65540; i++) tick();
        strobe_in = 1'b0;
        check("ovr_sat", {16'd0, overrun_cnt}, 32'h0000_FFFF);
        strobe();
        check("ovr_sat2", {16'd0, overrun_cnt}, 32'h0000_FFFF);
        out_ready = 1'b1;
        wait_idle();

        // Reset mid-frame at word 4
        strobe();
        for (int i = 0; i < 4; i++) tick();
        #1 sys_rst_n = 1'b0;
        #1;
        check("mrst_data", out_data, 32'd0);
        check("mrst_valid", {31'd0, out_valid}, 32'd0);
        check("mrst_last", {31'd0, out_last}, 32'd0);
        check("mrst_busy", {31'd0, busy}, 32'd0);
        check("mrst_fcnt", {16'd0, frame_cnt}, 32'd0);
        check("mrst_ovr", {16'd0, overrun_cnt}, 32'd0);
        tick();
        sys_rst_n = 1'b1;
        tick();

        // Back-to-back frames
        set_all(21'd3, 22'd4);
        strobe();
        check("b2b_hdr0", out_data, 32'hA500_0008);
        for (int i = 0; i < 8; i++) tick();
        set_all(21'd5, 22'd6);
        strobe();
        check("b2b_valid", {31'd0, out_valid}, 32'd1);
        check("b2b_hdr1", out_data, 32'hA500_0108);
        wait_idle();
        check("b2b_fcnt", {16'd0, frame_cnt}, 32'd2);

        // Strobe while disabled
        enable = 1'b0;
        strobe();
        check("dis_valid", {31'd0, out_valid}, 32'd0);
        check("dis_ovr", {16'd0, overrun_cnt}, 32'd0);
        tick();
        enable = 1'b1;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
